// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array sequencing controller.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sa_state_e;

  localparam int ROWS_DEF  = 4;
  localparam int COLS_DEF  = 4;
  localparam int K_DIM_DEF = 8;

  // Number of FEED cycles: the last lane (largest offset) needs K_DIM reads.
  function automatic int t_feed(input int rows, input int cols, input int k_dim);
    return k_dim + ((rows > cols) ? rows : cols) - 1;
  endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// One skewed operand feed: reads k = t-OFFSET while t sits in [OFFSET, OFFSET+K_DIM).
module sa_skew_lane #(
  parameter int OFFSET = 0,
  parameter int K_DIM  = 8,
  parameter int TW     = 4,
  parameter int KW     = $clog2(K_DIM)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [TW-1:0] t,
  input  logic          adv,
  input  logic          hold,
  output logic          rd_en,
  output logic [KW-1:0] rd_addr,
  output logic          valid
);

  localparam int DW = TW + 1;

  logic [DW-1:0] diff;
  logic          in_win;

  // Extra MSB acts as the borrow: set when t is still below this lane's offset.
  assign diff    = {1'b0, t} - DW'(OFFSET);
  assign in_win  = ~diff[DW-1] && (diff < DW'(K_DIM));
  assign rd_en   = adv & in_win;
  assign rd_addr = rd_en ? diff[KW-1:0] : '0;

  // Valid trails the read by the buffer's one-cycle latency and freezes during a stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= 1'b0;
    end else if (!hold) begin
      valid <= rd_en;
    end
  end

endmodule

// File: rtl/sa_sched_ctrl.sv
// Tile sequencer for an output-stationary ROWS x COLS systolic array.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; t parked at 0
//   FEED  | t steps 0..T_FEED-1 issuing skewed A/B buffer reads
//   DRAIN | no reads; array runs until bottom-right PE reports C valid
//   DONE  | one-cycle done pulse, then back to IDLE
module sa_sched_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int K_DIM = K_DIM_DEF,
  parameter int KW    = $clog2(K_DIM)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               stall,
  input  logic               c_last_valid,
  output logic               busy,
  output logic               done,
  output logic               pe_en,
  output logic [ROWS-1:0]    a_rd_en,
  output logic [ROWS*KW-1:0] a_rd_addr,
  output logic [ROWS-1:0]    a_valid,
  output logic [COLS-1:0]    b_rd_en,
  output logic [COLS*KW-1:0] b_rd_addr,
  output logic [COLS-1:0]    b_valid
);

  localparam int T_FEED = t_feed(ROWS, COLS, K_DIM);
  localparam int TW     = $clog2(T_FEED);
  localparam logic [TW-1:0] T_LAST = TW'(T_FEED - 1);

  sa_state_e     state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic          adv, hold;

  // State and feed-step registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // Next state; a stall freezes both state and t while busy.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        t_d = '0;
        if (start) state_d = FEED;
      end
      FEED: begin
        if (!stall) begin
          if (t_q == T_LAST) state_d = DRAIN;
          else               t_d     = t_q + 1'b1;
        end
      end
      DRAIN: begin
        if (c_last_valid && !stall) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == FEED) || (state_q == DRAIN);
  assign done  = (state_q == DONE);
  assign pe_en = busy & ~stall;
  assign adv   = (state_q == FEED) & ~stall;
  assign hold  = busy & stall;

  for (genvar r = 0; r < ROWS; r++) begin : g_a
    sa_skew_lane #(.OFFSET(r), .K_DIM(K_DIM), .TW(TW), .KW(KW)) u_lane (
      .CLK     (CLK),
      .RST     (RST),
      .t       (t_q),
      .adv     (adv),
      .hold    (hold),
      .rd_en   (a_rd_en[r]),
      .rd_addr (a_rd_addr[r*KW +: KW]),
      .valid   (a_valid[r])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b
    sa_skew_lane #(.OFFSET(c), .K_DIM(K_DIM), .TW(TW), .KW(KW)) u_lane (
      .CLK     (CLK),
      .RST     (RST),
      .t       (t_q),
      .adv     (adv),
      .hold    (hold),
      .rd_en   (b_rd_en[c]),
      .rd_addr (b_rd_addr[c*KW +: KW]),
      .valid   (b_valid[c])
    );
  end

endmodule

// File: tb/tb_sa_sched_ctrl.sv
// Self-checking bench for sa_sched_ctrl: vector table, directed corner cases, random run.
module tb_sa_sched_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int K_DIM = 8;
  localparam int KW    = 3;
  localparam int TF    = K_DIM + 4 - 1;
  // Enabled cycles until the bottom-right PE of a 4x4 array has consumed its last pair.
  localparam int CLV_BASE = (ROWS - 1) + (COLS - 1) + K_DIM + 1;

  logic CLK = 1'b0;
  logic RST, start, stall, c_last_valid;
  logic busy, done, pe_en;
  logic [ROWS-1:0]    a_rd_en, a_valid;
  logic [ROWS*KW-1:0] a_rd_addr;
  logic [COLS-1:0]    b_rd_en, b_valid;
  logic [COLS*KW-1:0] b_rd_addr;

  logic start2, clv2;
  logic n_busy, n_done, n_pe_en;
  logic [1:0]  n_a_rd_en, n_a_valid;
  logic [5:0]  n_a_rd_addr;
  logic [3:0]  n_b_rd_en, n_b_valid;
  logic [11:0] n_b_rd_addr;

  always #5 CLK = ~CLK;

  sa_sched_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_DIM(K_DIM)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stall(stall), .c_last_valid(c_last_valid),
    .busy(busy), .done(done), .pe_en(pe_en),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_valid(a_valid),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_valid(b_valid)
  );

  sa_sched_ctrl #(.ROWS(2), .COLS(4), .K_DIM(8)) dut_ns (
    .CLK(CLK), .RST(RST), .start(start2), .stall(stall), .c_last_valid(clv2),
    .busy(n_busy), .done(n_done), .pe_en(n_pe_en),
    .a_rd_en(n_a_rd_en), .a_rd_addr(n_a_rd_addr), .a_valid(n_a_valid),
    .b_rd_en(n_b_rd_en), .b_rd_addr(n_b_rd_addr), .b_valid(n_b_valid)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  // Reference model: phase 0 idle, 1 feed, 2 drain, 3 done; m_s = feed steps taken.
  int   m_phase = 0;
  int   m_s = 0;
  int   en_cnt = 0;
  int   clv_thr = CLV_BASE;
  bit   m_known = 0;
  bit   auto_clv = 1;
  bit   rand_clv = 0;
  logic clv_force = 1'b0;
  logic [31:0] m_aval = '0, m_bval = '0;

  byte unsigned mA[ROWS][K_DIM];
  byte unsigned mB[K_DIM][COLS];
  int qa[ROWS][$];
  int qb[COLS][$];

  logic obs_busy, obs_done;
  logic [31:0] obs_all;
  logic [3:0]  obs_a_en, obs_a_val, obs_b_en;
  logic obs2_busy, obs2_done;
  logic [31:0] obs2_a_en, obs2_b_en, obs2_b3_addr;

  typedef struct {
    logic rst, start, stall;
    logic busy, done, pe;
    logic [3:0] en, val;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] win(input int n, input int s);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = (s >= i) && (s < i + K_DIM);
    return v;
  endfunction

  task automatic new_tile();
    en_cnt = 0;
    clv_thr = CLV_BASE + (rand_clv ? int'($urandom_range(0, 4)) : 0);
    for (int r = 0; r < ROWS; r++) qa[r].delete();
    for (int c = 0; c < COLS; c++) qb[c].delete();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < K_DIM; k++) mA[r][k] = 8'($urandom);
    for (int k = 0; k < K_DIM; k++)
      for (int c = 0; c < COLS; c++) mB[k][c] = 8'($urandom);
  endtask

  // Multiply-accumulate what the array would see from the captured address streams.
  task automatic check_c();
    int nbad = 0;
    for (int r = 0; r < ROWS; r++) if (qa[r].size() != K_DIM) nbad += 100;
    for (int c = 0; c < COLS; c++) if (qb[c].size() != K_DIM) nbad += 100;
    if (nbad == 0) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          int ref_c = 0;
          int pe_c = 0;
          for (int k = 0; k < K_DIM; k++) begin
            ref_c += int'(mA[r][k]) * int'(mB[k][c]);
            pe_c  += int'(mA[r][qa[r][k]]) * int'(mB[qb[c][k]][c]);
          end
          if ((ref_c & 32'h7FFFF) != (pe_c & 32'h7FFFF)) nbad++;
        end
    end
    chk("tile_c_errors", 32'(nbad), 32'd0);
  endtask

  task automatic step();
    logic [31:0] ea, eb, amask, aexp, bmask, bexp;
    logic e_busy, e_pe;
    if (auto_clv) c_last_valid = (m_phase == 2) && (en_cnt >= clv_thr);
    else          c_last_valid = clv_force;
    #4;
    obs_busy  = busy;
    obs_done  = done;
    obs_a_en  = a_rd_en;
    obs_a_val = a_valid;
    obs_b_en  = b_rd_en;
    obs_all   = {11'd0, busy, done, pe_en, a_rd_en, b_rd_en, a_valid, b_valid, 2'd0};
    obs2_busy = n_busy;
    obs2_done = n_done;
    obs2_a_en = 32'(n_a_rd_en);
    obs2_b_en = 32'(n_b_rd_en);
    obs2_b3_addr = 32'(n_b_rd_addr[9 +: 3]);
    e_busy = (m_phase == 1) || (m_phase == 2);
    e_pe   = e_busy && !stall;
    ea = (m_phase == 1 && !stall) ? win(ROWS, m_s) : 32'd0;
    eb = (m_phase == 1 && !stall) ? win(COLS, m_s) : 32'd0;
    amask = '0; aexp = '0; bmask = '0; bexp = '0;
    for (int r = 0; r < ROWS; r++)
      if (ea[r]) begin amask[r*KW +: KW] = '1; aexp[r*KW +: KW] = KW'(m_s - r); end
    for (int c = 0; c < COLS; c++)
      if (eb[c]) begin bmask[c*KW +: KW] = '1; bexp[c*KW +: KW] = KW'(m_s - c); end
    if (m_known) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(m_phase == 3));
      chk("pe_en", 32'(pe_en), 32'(e_pe));
      chk("a_rd_en", 32'(a_rd_en), ea);
      chk("b_rd_en", 32'(b_rd_en), eb);
      chk("a_rd_addr", 32'(a_rd_addr) & amask, aexp);
      chk("b_rd_addr", 32'(b_rd_addr) & bmask, bexp);
      chk("a_valid", 32'(a_valid), m_aval);
      chk("b_valid", 32'(b_valid), m_bval);
    end
    for (int r = 0; r < ROWS; r++) if (a_rd_en[r]) qa[r].push_back(int'(a_rd_addr[r*KW +: KW]));
    for (int c = 0; c < COLS; c++) if (b_rd_en[c]) qb[c].push_back(int'(b_rd_addr[c*KW +: KW]));
    if (done === 1'b1) begin
      done_cnt++;
      check_c();
    end
    @(posedge CLK);
    if (RST) begin
      m_known = 1; m_phase = 0; m_s = 0; m_aval = '0; m_bval = '0; en_cnt = 0;
    end else if (m_known) begin
      if (!(e_busy && stall)) begin m_aval = ea; m_bval = eb; end
      if (e_pe) en_cnt++;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_s = 0; new_tile(); end
        1: if (!stall) begin if (m_s == TF - 1) m_phase = 2; else m_s++; end
        2: if (c_last_valid && !stall) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic run_tile(input int stall_at, input int stall_len, input bit poke, output int lat);
    int d0 = done_cnt;
    int guard = 0;
    int sc = 0;
    start = 1'b1; stall = 1'b0;
    step();
    start = 1'b0;
    lat = 0;
    while (done_cnt == d0 && guard < 300) begin
      if (m_phase == 1 && m_s == stall_at && sc < stall_len) begin stall = 1'b1; sc++; end
      else stall = 1'b0;
      start = poke && (m_phase == 3 || (m_phase == 1 && m_s == 4));
      step();
      lat++;
      guard++;
    end
    start = 1'b0; stall = 1'b0;
    if (guard >= 300) chk("tile_timeout", 32'(guard), 32'd0);
  endtask

  vec_t tbl[10];
  int lat1, lat2, lat3, d0, guard;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 4'b0001};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0011};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0111, 4'b0011};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b0111};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b1111};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};

    RST = 1'b1; start = 1'b0; stall = 1'b0; c_last_valid = 1'b0;
    start2 = 1'b0; clv2 = 1'b0;
    step();
    step();
    chk("reset_outputs", obs_all, 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 10; i++) begin
      RST = tbl[i].rst; start = tbl[i].start; stall = tbl[i].stall;
      step();
      chk($sformatf("tbl%0d_busy", i), 32'(obs_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(obs_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_pe", i), 32'(obs_all[18]), 32'(tbl[i].pe));
      chk($sformatf("tbl%0d_a_en", i), 32'(obs_a_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_b_en", i), 32'(obs_b_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_a_val", i), 32'(obs_a_val), 32'(tbl[i].val));
    end
    RST = 1'b0; start = 1'b0; stall = 1'b0;

    // Plain tile: done appears two cycles after the CLV threshold of enabled cycles.
    run_tile(-1, 0, 1'b0, lat1);
    chk("lat_nostall", 32'(lat1), 32'(CLV_BASE + 2));

    // Three stall cycles at t=5 push done out by exactly three.
    run_tile(5, 3, 1'b0, lat2);
    chk("lat_stall3", 32'(lat2 - lat1), 32'd3);

    // start during FEED and DONE is ignored.
    d0 = done_cnt;
    run_tile(-1, 0, 1'b1, lat3);
    for (int i = 0; i < 10; i++) step();
    chk("poke_done_once", 32'(done_cnt - d0), 32'd1);
    chk("poke_latency", 32'(lat3), 32'(lat1));
    chk("poke_idle_busy", 32'(obs_busy), 32'd0);

    // Reset at t=6 aborts the tile; a late c_last_valid must not produce done.
    start = 1'b1; step(); start = 1'b0;
    guard = 0;
    while (!(m_phase == 1 && m_s == 6) && guard < 50) begin step(); guard++; end
    chk("abort_reach_t6", 32'(m_s), 32'd6);
    RST = 1'b1; step(); RST = 1'b0;
    auto_clv = 0; clv_force = 1'b1;
    d0 = done_cnt;
    step();
    chk("abort_outputs", obs_all, 32'd0);
    for (int i = 0; i < 30; i++) step();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    auto_clv = 1; clv_force = 1'b0;

    // Back-to-back tiles, each with fresh operands.
    d0 = done_cnt;
    run_tile(-1, 0, 1'b0, lat3);
    run_tile(-1, 0, 1'b0, lat3);
    chk("b2b_dones", 32'(done_cnt - d0), 32'd2);

    // Non-square 2x4 instance.
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int t = 0; t < TF; t++) begin
      step();
      chk($sformatf("ns_a_en_t%0d", t), obs2_a_en, win(2, t));
      chk($sformatf("ns_b_en_t%0d", t), obs2_b_en, win(4, t));
      if (t >= 3) chk($sformatf("ns_b3_addr_t%0d", t), obs2_b3_addr, 32'(t - 3));
    end
    step();
    chk("ns_drain_busy", 32'(obs2_busy), 32'd1);
    chk("ns_drain_rd", obs2_a_en | obs2_b_en, 32'd0);
    clv2 = 1'b1; step(); clv2 = 1'b0;
    step();
    chk("ns_done", 32'(obs2_done), 32'd1);
    step();

    // Random stall/start/reset traffic against the model.
    rand_clv = 1;
    for (int i = 0; i < 2500; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 7) == 0);
      RST   = ($urandom_range(0, 299) == 0);
      step();
    end
    RST = 1'b0; start = 1'b0; stall = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_sched_ctrl.md
Name: sa_sched_ctrl

Overview:
- Sequencing controller for a ROWS x COLS output-stationary systolic array of hPE cells.
- On a start pulse it generates skewed per-row A and per-column B operand-buffer reads and the matching valid strobes.
- It drives the array-wide PE enable, then waits for the bottom-right PE's C valid and pulses done.
- It sits between the tile loader (A/B operand buffers) and the PE array.

Parameters:
- ROWS, 4, array rows (A feeds, one per row)
- COLS, 4, array columns (B feeds, one per column)
- K_DIM, 8, dot-product length; must equal the PE's K_DIM
- KW, $clog2(K_DIM), operand-buffer address width

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run one tile
- stall  in  1  freeze request from buffers or downstream
- c_last_valid  in  1  C_valid_out of PE[ROWS-1][COLS-1]
- busy  out  1  high in FEED or DRAIN
- done  out  1  one-cycle pulse, tile complete
- pe_en  out  1  EN to every PE
- a_rd_en  out  ROWS  per-row A buffer read enable
- a_rd_addr  out  ROWS*KW  per-row k index; row r occupies bits [r*KW +: KW]
- a_valid  out  ROWS  A_valid_in to column-0 PE of each row
- b_rd_en  out  COLS  per-column B buffer read enable
- b_rd_addr  out  COLS*KW  per-column k index
- b_valid  out  COLS  B_valid_in to row-0 PE of each column

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is CLK, reset port is RST.
- Reset state (RST=1 at a CLK edge): state=IDLE, t=0, and all outputs 0.
- Reset mid-operation aborts the tile. No done is produced. The array's own reset is handled separately.
- FSM states are IDLE, FEED, DRAIN, DONE.
- IDLE: start=1 -> FEED, t=0. start is ignored in every other state.
- FEED: counter t runs 0..T_FEED-1, where T_FEED = K_DIM + max(ROWS,COLS) - 1.
  - Row r: a_rd_en[r]=1 iff r <= t < r+K_DIM, with a_rd_addr[r]=t-r.
  - Column c is the same using c.
  - At t=T_FEED-1 with no stall -> DRAIN.
- Read latency:
  - Operand buffers have 1-cycle read latency and hold their output when rd_en=0.
  - a_valid[r] and b_valid[c] are registered copies of a_rd_en[r] and b_rd_en[c], so they align with buffer data.
  - In DRAIN they return to 0 one cycle after the last read.
- DRAIN: waits for c_last_valid=1 (sampled while pe_en=1) -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. busy=0 in DONE.
- pe_en = busy & ~stall, combinational from registered state plus stall.
- stall=1 (FEED or DRAIN), in the same cycle:
  - pe_en=0 and all rd_en=0.
  - t, state and the valid registers hold.
  - On release the sequence resumes exactly where it stopped. No read is skipped or duplicated.
- stall in IDLE or DONE has no effect. done is not delayed by stall.
- start coinciding with DONE is ignored; requesters retry after done.
- No accumulator clear is issued. The PE restarts its accumulation at k_cnt==0, so back-to-back tiles need no gap beyond the IDLE cycle.
- Width rules: t is wide enough for T_FEED-1 (clog2(T_FEED)). Address subtraction is unsigned and used only inside the enable window, so no wrap-around is possible.

Decomposition:
- Package sa_pkg holds: the state enum (IDLE/FEED/DRAIN/DONE), ROWS/COLS/K_DIM defaults, and a T_FEED function.
- One sub-module, sa_skew_lane:
  - Parameters OFFSET and K_DIM; inputs t, adv (=~stall in FEED).
  - Outputs rd_en, rd_addr, and a registered valid.
  - Generated ROWS times for A and COLS times for B.

Test Plan:
- Single tile, ROWS=COLS=4, K_DIM=8, no stall:
  - FEED lasts 11 cycles.
  - a_rd_addr[0] = 0..7 at t=0..7; a_rd_addr[3] = 0..7 at t=3..10.
  - a_valid[r] trails a_rd_en[r] by 1 cycle.
  - Fed PE model yields correct 19-bit C; done is 1 cycle after c_last_valid.
- Stall of 3 cycles at t=5:
  - pe_en=0 and rd_en all 0 for those 3 cycles.
  - Address stream resumes at t=5 with no gaps or repeats.
  - done is delayed by exactly 3 cycles vs scenario 1.
- start pulsed during FEED and during DONE: ignored. Exactly one done, and busy never re-asserts until a new start in IDLE.
- RST=1 at t=6 of FEED: the next cycle has every output 0 and state IDLE. No done pulse follows, even if c_last_valid later arrives.
- Back-to-back tiles (start in the cycle after done):
  - Two done pulses.
  - Second-tile C values are independent of the first (no residual accumulation).
- Non-square ROWS=2, COLS=4: T_FEED=11; b lane 3 reads at t=3..10; row lanes finish at t=8 and stay 0 until DRAIN.
